// File: rtl/l2_arb_pkg.sv
// Shared types and widths for the L2 port arbiter.
package l2_arb_pkg;

    localparam int unsigned LINE_W = 512;
    localparam int unsigned DM_W   = 64;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } grant_t;

endpackage

// File: rtl/l2_port_arbiter_pick.sv
// Combinational winner select for the two L1 requesters.
// L2ARB_ROUND_ROBIN_EN: break ties against the last-served master instead of fixed M1 priority.
module l2_arb_pick
    import l2_arb_pkg::*;
(
    input  logic   stb0,
    input  logic   stb1,
`ifdef L2ARB_ROUND_ROBIN_EN
    input  grant_t last,
`endif
    output logic   any,
    output grant_t win
);

    always_comb begin
        any = stb0 | stb1;
        win = M0;
        if (stb0 && stb1) begin
`ifdef L2ARB_ROUND_ROBIN_EN
            win = (last == M1) ? M0 : M1;
`else
            win = M1;
`endif
        end else if (stb1) begin
            win = M1;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Two-master arbiter in front of the single L2 Wishbone slave port, with ack watchdog.
// L2ARB_ROUND_ROBIN_EN: enables round-robin tie breaking via a last-served register.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [LINE_W-1:0]   m0_din,
    input  logic [DM_W-1:0]     m0_dm,
    input  logic                m0_we,
    input  logic                m0_stb,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [LINE_W-1:0]   m0_dout,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [LINE_W-1:0]   m1_din,
    input  logic [DM_W-1:0]     m1_dm,
    input  logic                m1_we,
    input  logic                m1_stb,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [LINE_W-1:0]   m1_dout,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [LINE_W-1:0]   s_din,
    output logic [DM_W-1:0]     s_dm,
    output logic                s_we,
    output logic                s_stb,
    input  logic                s_ack,
    input  logic [LINE_W-1:0]   s_dout
);

    state_t           state;
    state_t           state_nxt;
    grant_t           grant;
    grant_t           pick_win;
    logic             pick_any;
    logic [CNT_W-1:0] wd;
    logic             timeout;

`ifdef L2ARB_ROUND_ROBIN_EN
    grant_t last_served;

    l2_arb_pick u_pick (
        .stb0 (m0_stb),
        .stb1 (m1_stb),
        .last (last_served),
        .any  (pick_any),
        .win  (pick_win)
    );
`else
    l2_arb_pick u_pick (
        .stb0 (m0_stb),
        .stb1 (m1_stb),
        .any  (pick_any),
        .win  (pick_win)
    );
`endif

    assign timeout = (wd == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_stb     = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        unique case (state)
            IDLE:  if (pick_any) state_nxt = ISSUE;
            ISSUE: begin
                s_stb     = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  if (s_ack || timeout) state_nxt = RESP;
            RESP: begin
                m0_ack    = (grant == M0);
                m1_ack    = (grant == M1);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant   <= M0;
            wd      <= '0;
            s_addr  <= '0;
            s_din   <= '0;
            s_dm    <= '0;
            s_we    <= 1'b0;
            m0_dout <= '0;
            m1_dout <= '0;
            m0_err  <= 1'b0;
            m1_err  <= 1'b0;
`ifdef L2ARB_ROUND_ROBIN_EN
            last_served <= M0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_win;
                        if (pick_win == M1) begin
                            s_addr <= m1_addr;
                            s_din  <= m1_din;
                            s_dm   <= m1_dm;
                            s_we   <= m1_we;
                        end else begin
                            s_addr <= m0_addr;
                            s_din  <= m0_din;
                            s_dm   <= m0_dm;
                            s_we   <= m0_we;
                        end
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    wd <= wd + CNT_W'(1);
                    // An ack on the timeout cycle still completes normally.
                    if (s_ack) begin
                        if (grant == M1) begin
                            m1_dout <= s_dout;
                            m1_err  <= 1'b0;
                        end else begin
                            m0_dout <= s_dout;
                            m0_err  <= 1'b0;
                        end
                    end else if (timeout) begin
                        if (grant == M1) begin
                            m1_dout <= '0;
                            m1_err  <= 1'b1;
                        end else begin
                            m0_dout <= '0;
                            m0_err  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    m0_err <= 1'b0;
                    m1_err <= 1'b0;
`ifdef L2ARB_ROUND_ROBIN_EN
                    last_served <= grant;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: vector table, corner sequences, randomized rounds.
module tb_l2_port_arbiter;

    localparam int TO = 16;

    logic         clk;
    logic         rst;
    logic [31:0]  addr_q [2];
    logic [511:0] din_q  [2];
    logic [63:0]  dm_q   [2];
    logic         we_q   [2];
    logic         stb_q  [2];
    logic [511:0] rdat   [2];
    int           dly    [2];
    logic [511:0] hold   [2];
    int           last;

    logic         m0_ack, m0_err, m1_ack, m1_err;
    logic [511:0] m0_dout, m1_dout;
    logic [31:0]  s_addr;
    logic [511:0] s_din;
    logic [63:0]  s_dm;
    logic         s_we, s_stb, s_ack;
    logic [511:0] s_dout;

    int passed = 0;
    int total  = 0;

    l2_port_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_addr (addr_q[0]),
        .m0_din  (din_q[0]),
        .m0_dm   (dm_q[0]),
        .m0_we   (we_q[0]),
        .m0_stb  (stb_q[0]),
        .m0_ack  (m0_ack),
        .m0_err  (m0_err),
        .m0_dout (m0_dout),
        .m1_addr (addr_q[1]),
        .m1_din  (din_q[1]),
        .m1_dm   (dm_q[1]),
        .m1_we   (we_q[1]),
        .m1_stb  (stb_q[1]),
        .m1_ack  (m1_ack),
        .m1_err  (m1_err),
        .m1_dout (m1_dout),
        .s_addr  (s_addr),
        .s_din   (s_din),
        .s_dm    (s_dm),
        .s_we    (s_we),
        .s_stb   (s_stb),
        .s_ack   (s_ack),
        .s_dout  (s_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    typedef struct {
        bit          r0, r1, we0, we1;
        logic [31:0] a0, a1, wd0, wd1, rd0, rd1;
        logic [63:0] dm0, dm1;
        int          d0, d1;
        int          first;
        bit          e0, e1;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int ack_of(input int w);
        return (w == 1) ? int'(m1_ack) : int'(m0_ack);
    endfunction

    // Reference arbitration rule, tracked at transaction level.
    function automatic int model_pick(input logic a0, input logic a1);
        if (a0 && a1) begin
`ifdef L2ARB_ROUND_ROBIN_EN
            return (last == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        return a1 ? 1 : 0;
    endfunction

    task automatic req(input int w, input logic [31:0] a, input logic we, input logic [511:0] d,
                       input logic [63:0] dm, input logic [511:0] rd, input int dl);
        addr_q[w] = a; we_q[w] = we; din_q[w] = d; dm_q[w] = dm;
        rdat[w] = rd; dly[w] = dl; stb_q[w] = 1'b1;
    endtask

    task automatic chk_quiet(input int w);
        chk("wait_quiet", {509'd0, s_stb, m0_ack, m1_ack}, '0);
        chk("wait_din_stable", s_din, din_q[w]);
        chk("wait_ctl_stable", {415'd0, s_addr, s_dm, s_we}, {415'd0, addr_q[w], dm_q[w], we_q[w]});
    endtask

    task automatic txn(input int w, input bit keep, input bit exp_err);
        int n;
        int o;
        logic [511:0] exp_dout;
        o = 1 - w;
        n = 0;
        while (s_stb !== 1'b1 && n < 8) begin tick(); n++; end
        chk("issue_stb", s_stb, 1'b1);
        chk("issue_addr", s_addr, addr_q[w]);
        chk("issue_we", s_we, we_q[w]);
        chk("issue_din", s_din, din_q[w]);
        chk("issue_dm", s_dm, dm_q[w]);
        if (!exp_err) begin
            for (int k = 0; k < dly[w]; k++) begin tick(); chk_quiet(w); end
            s_ack = 1'b1; s_dout = rdat[w];
            tick();
            s_ack = 1'b0; s_dout = rnd512();
            exp_dout = rdat[w];
        end else begin
            for (int k = 0; k < TO; k++) begin tick(); chk_quiet(w); end
            tick();
            exp_dout = '0;
        end
        chk("resp_ack", ack_of(w), 1);
        chk("resp_other_ack", ack_of(o), 0);
        chk("resp_err", (w == 1) ? m1_err : m0_err, exp_err);
        chk("resp_other_err", (w == 1) ? m0_err : m1_err, 1'b0);
        chk("resp_dout", (w == 1) ? m1_dout : m0_dout, exp_dout);
        chk("resp_other_dout_hold", (w == 1) ? m0_dout : m1_dout, hold[o]);
        chk("resp_no_stb", s_stb, 1'b0);
        hold[w] = exp_dout;
        last = w;
        if (!keep) stb_q[w] = 1'b0;
        tick();
        chk("ack_one_cycle", {509'd0, m0_ack, m1_ack, s_stb}, '0);
        if (exp_err && !keep && !stb_q[o]) begin
            tick(); tick();
            s_ack = 1'b1;
            tick();
            s_ack = 1'b0;
            chk("late_ack_ignored", {508'd0, m0_ack, m1_ack, m0_err, m1_err}, '0);
            tick();
            chk("late_ack_no_issue", {509'd0, m0_ack, m1_ack, s_stb}, '0);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {413'd0, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err, s_addr, s_dm}, '0);
        chk({nm, "_din"}, s_din, '0);
        chk({nm, "_dout0"}, m0_dout, '0);
        chk({nm, "_dout1"}, m1_dout, '0);
    endtask

    initial begin
        int n;
        int w;
        int e;
        vec_t v;
        rst = 1'b1; s_ack = 1'b0; s_dout = '0; last = 0;
        for (int i = 0; i < 2; i++) begin
            addr_q[i] = '0; din_q[i] = '0; dm_q[i] = '0; we_q[i] = 1'b0;
            stb_q[i] = 1'b0; rdat[i] = '0; dly[i] = 1; hold[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        tick();

        //         r0    r1    we0   we1   a0            a1            wd0           wd1           rd0           rd1           dm0                    dm1                    d0  d1  first e0    e1
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h003F_FFC0, 32'h0,       32'h0,        32'h0,        32'h1234_5678, 32'h0,       64'h0,                 64'h0,                 5,  0,  0,    1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_1040, 32'h0,       32'h8765_4321, 32'h0,       32'hDEAD_BEEF, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 0, 3, 1,   1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0,       32'hA5A5_5A5A, 32'h0,       32'h0BAD_F00D, 32'h0,       64'h0000_00FF_0000_FF00, 64'h0,               1,  0,  0,    1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_3040, 32'h0,       32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 64'h0,               64'h0F0F_0F0F_0F0F_0F0F, 2, 16, 1,  1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_4000, 32'h0,       32'h0,        32'h0,        32'h7777_8888, 64'h0,                 64'h0,                 0,  99, 1,    1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'h0,       32'h0,        32'h0,        32'h9999_AAAA, 32'h0,       64'h0,                 64'h0,                 17, 0,  0,    1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_6000, 32'h0000_6040, 32'hCAFE_BABE, 32'h0,     32'h0101_0101, 32'h0202_0202, 64'hFFFF_0000_FFFF_0000, 64'h0,             4,  7,  1,    1'b0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            v = tbl[i];
            if (v.r0) req(0, v.a0, v.we0, {16{v.wd0}}, v.dm0, {16{v.rd0}}, v.d0);
            if (v.r1) req(1, v.a1, v.we1, {16{v.wd1}}, v.dm1, {16{v.rd1}}, v.d1);
            w = v.first;
            txn(w, 1'b0, (w == 1) ? v.e1 : v.e0);
            if (v.r0 && v.r1) txn(1 - w, 1'b0, (w == 1) ? v.e0 : v.e1);
        end

        // Held m0 strobe: one transaction per IDLE visit.
        req(0, 32'h0000_7000, 1'b0, rnd512(), '0, rnd512(), 2);
        for (int r = 0; r < 3; r++) begin
            txn(0, (r < 2), 1'b0);
            if (r < 2) begin
                tick();
                chk("b2b_reissue", s_stb, 1'b1);
            end
        end

        // Three back-to-back tie rounds with both strobes held.
        req(0, 32'h0000_8000, 1'b0, rnd512(), '0, rnd512(), 3);
        req(1, 32'h0000_8040, 1'b1, rnd512(), '1, rnd512(), 2);
        for (int r = 0; r < 3; r++) begin
`ifdef L2ARB_ROUND_ROBIN_EN
            w = (r == 1) ? 0 : 1;
`else
            w = 1;
`endif
            txn(w, (r < 2), 1'b0);
        end
        txn(1 - w, 1'b0, 1'b0);

        // Asynchronous reset while waiting on the L2.
        req(0, 32'h0000_9000, 1'b0, rnd512(), '0, rnd512(), 4);
        n = 0;
        while (s_stb !== 1'b1 && n < 8) begin tick(); n++; end
        chk("rst_issue_seen", s_stb, 1'b1);
        tick(); tick();
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        stb_q[0] = 1'b0;
        hold[0] = '0; hold[1] = '0; last = 0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        req(0, 32'h0000_A000, 1'b0, rnd512(), '0, rnd512(), 4);
        txn(0, 1'b0, 1'b0);

        // Randomized rounds against the transaction-level rule.
        for (int r = 0; r < 30; r++) begin
            logic a0, a1;
            a0 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom_range(0, 1));
            if (!a0 && !a1) a0 = 1'b1;
            for (int m = 0; m < 2; m++) begin
                if ((m == 0) ? a0 : a1)
                    req(m, $urandom & 32'hFFFF_FFC0, 1'($urandom_range(0, 1)), rnd512(),
                        {$urandom, $urandom}, rnd512(), int'($urandom_range(1, 19)));
            end
            n = 0;
            while ((stb_q[0] || stb_q[1]) && n < 4) begin
                w = model_pick(stb_q[0], stb_q[1]);
                e = (dly[w] > TO) ? 1 : 0;
                txn(w, 1'b0, e[0]);
                n++;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 cache Wishbone slave port (512-bit line, 64-bit byte mask) between two L1 requesters: M0 (instruction refill) and M1 (data refill/writeback).
- Sits between the L1 caches and the L2 cache.
- Converts each requester's held strobe into the one-cycle strobe pulse the L2 samples in its idle state.
- Returns the L2 response to the granted requester only.
- A watchdog aborts transactions the L2 never acknowledges.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles to wait for s_ack before aborting; range 16..65535.
- CNT_W, 16: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_addr  in  32  M0 line address; bits 5:0 ignored.
- m0_din  in  512  M0 write data.
- m0_dm  in  64  M0 byte-write mask.
- m0_we  in  1  M0 write enable.
- m0_stb  in  1  M0 request; held until m0_ack.
- m0_ack  out  1  M0 one-cycle completion pulse.
- m0_err  out  1  M0 timeout flag; valid with m0_ack.
- m0_dout  out  512  M0 read data; valid with m0_ack.
- m1_addr, m1_din, m1_dm, m1_we, m1_stb, m1_ack, m1_err, m1_dout: same as the M0 ports, for M1.
- s_addr  out  32  to L2.
- s_din  out  512  to L2.
- s_dm  out  64  to L2.
- s_we  out  1  to L2.
- s_stb  out  1  to L2; one-cycle pulse per transaction.
- s_ack  in  1  from L2.
- s_dout  in  512  from L2.

Behaviour:
- Reset:
  - While rst=1 (asynchronous): state=IDLE; all outputs 0; grant=M0; watchdog=0.
  - Reset mid-transaction drops the transaction silently; the L2 shares rst.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any m*_stb is high, choose the winner.
  - Latch the winner's addr/din/dm/we into s_* registers; record grant; go to ISSUE.
  - If neither is high, stay.
  - Choice: fixed priority M1 over M0 (default), or round-robin when the optional feature is enabled.
- ISSUE:
  - s_stb=1 for exactly this one cycle; clear watchdog; go to WAIT.
  - s_addr/s_din/s_dm/s_we stay stable from ISSUE until leaving WAIT.
- WAIT:
  - s_stb=0; watchdog increments each cycle.
  - On s_ack=1: register s_dout into the granted m*_dout; m*_err=0; go to RESP.
  - If s_ack is absent and watchdog == TIMEOUT_CYCLES-1: m*_dout=0, m*_err=1, go to RESP.
  - If s_ack arrives on the same cycle as the timeout, s_ack wins and err=0.
- RESP:
  - The granted m*_ack=1 for one cycle; the other master's ack stays 0.
  - Go to IDLE; m*_stb is ignored during this cycle.
  - Requesters must drop stb the cycle after ack.
  - A stb still high in the following IDLE is treated as a new request.
- Latency: request seen in IDLE at cycle N -> s_stb at N+1 -> ack returned at (s_ack cycle)+1. Minimum 3 cycles plus L2 latency.
- m*_dout holds its last value between transactions; only m*_ack/m*_err are pulsed.
- s_ack outside WAIT is ignored; this covers a late ack after a timeout.
- Writes: s_dout is ignored; m*_dout still loads s_dout for uniformity.
- Requests are never merged; one outstanding transaction at a time.

Optional Feature:
- Macro: L2ARB_ROUND_ROBIN_EN.
- Defined: a one-bit last-served register is updated in RESP. On simultaneous requests in IDLE, the master not served last wins. A single requester always wins. last-served resets to M0, so M1 wins the first tie.
- Undefined: fixed priority, M1 always beats M0; last-served logic is absent.

Decomposition:
- Package l2_arb_pkg:
  - State encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - LINE_W=512, DM_W=64, ADDR_W=32.
  - Grant encoding: M0=0, M1=1.
- One sub-module, l2_arb_pick (combinational winner select from stb pair and last-served). The FSM and datapath stay in the top.

Test Plan:
- Single read: m0_stb=1, m0_addr=0x003FFFC0, m0_we=0; L2 acks 5 cycles after s_stb with s_dout=0x1234_5678 repeated -> s_stb is one cycle with s_addr=0x003FFFC0; m0_ack is one cycle with m0_dout equal to that data; m0_err=0; m1_ack stays 0.
- Simultaneous: m0_stb and m1_stb rise on the same cycle.
  - Fixed priority: M1 is served first, then M0. Two s_stb pulses in order M1, M0.
  - L2ARB_ROUND_ROBIN_EN defined: with three back-to-back tie rounds, grants alternate M1, M0, M1.
- Write path: m1_we=1, m1_dm=0xFFFF_FFFF_FFFF_FFFF, m1_din=0x8765_4321 repeated -> s_we=1; s_din and s_dm match and are stable through WAIT; m1_ack after s_ack.
- Timeout: TIMEOUT_CYCLES=16 and L2 never acks -> m0_ack and m0_err together at ISSUE+17; m0_dout=0. A late s_ack 3 cycles later produces no ack. The next request is served normally.
- Async reset in WAIT: assert rst between clock edges -> all outputs go to 0 immediately. After release, a fresh m0 request completes normally.
- Back-to-back: m0 keeps stb asserted continuously -> exactly one transaction per IDLE visit, with no s_stb during RESP.
